enet_nios_period_timer: RTL and testbench



---
 rtl/enet_nios_timer_pkg.sv | 28 ++
 rtl/enet_nios_timer_counter.sv | 41 ++++
 rtl/enet_nios_period_timer.sv | 165 ++++++++++++++++
 tb/tb_enet_nios_period_timer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enet_nios_timer_pkg.sv
// Shared constants and types for the enet_nios period timer: register map,
// control/status bit positions, default widths and FSM states.
package enet_nios_timer_pkg;

   localparam int unsigned DATA_W_DEF  = 16;
   localparam int unsigned COUNT_W_DEF = 32;
   localparam int unsigned ADDR_W      = 3;

   localparam logic [ADDR_W-1:0] ADDR_STATUS  = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_CONTROL = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_PERIODL = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_PERIODH = 3'd3;
   localparam logic [ADDR_W-1:0] ADDR_SNAPL   = 3'd4;
   localparam logic [ADDR_W-1:0] ADDR_SNAPH   = 3'd5;

   localparam int unsigned STATUS_TO_BIT  = 0;
   localparam int unsigned STATUS_RUN_BIT = 1;
   localparam int unsigned CTRL_ITO_BIT   = 0;
   localparam int unsigned CTRL_CONT_BIT  = 1;
   localparam int unsigned CTRL_START_BIT = 2;
   localparam int unsigned CTRL_STOP_BIT  = 3;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } timer_state_e;

endpackage

// File: rtl/enet_nios_timer_counter.sv
// Loadable down-counter with synchronous load and enable; tc flags a zero count.
module enet_nios_timer_counter
   import enet_nios_timer_pkg::*;
#(
   parameter int unsigned          COUNT_W   = COUNT_W_DEF,
   parameter logic [COUNT_W-1:0]   RESET_VAL = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ena,
   input  logic               sload,
   input  logic [COUNT_W-1:0] load_value,
   output logic [COUNT_W-1:0] count,
   output logic               tc
);

   logic [COUNT_W-1:0] count_q;
   logic [COUNT_W-1:0] count_d;

   // Load has priority over decrement.
   always_comb begin
      count_d = count_q;
      if (sload) begin
         count_d = load_value;
      end else if (ena) begin
         count_d = count_q - COUNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= RESET_VAL;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign tc    = (count_q == '0);

endmodule

// File: rtl/enet_nios_period_timer.sv
// Avalon-slave programmable interval timer: periodic tick, sticky timeout and IRQ.
// Optional snapshot registers at addresses 4/5 are enabled by ENET_NIOS_TIMER_SNAPSHOT_EN.
module enet_nios_period_timer
   import enet_nios_timer_pkg::*;
#(
   parameter int unsigned        DATA_W       = DATA_W_DEF,
   parameter int unsigned        COUNT_W      = 2 * DATA_W,
   parameter logic [COUNT_W-1:0] RESET_PERIOD = COUNT_W'(49999),
   parameter bit                 ALWAYS_RUN   = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] readdata,
   output logic              irq,
   output logic              timeout_pulse
);

   timer_state_e state_q, state_d;
   logic               to_q, to_d;
   logic               ito_q, ito_d;
   logic               cont_q, cont_d;
   logic               pulse_q, pulse_d;
   logic [COUNT_W-1:0] period_q, period_d;

   logic               wr_en, wr_status, wr_ctrl, wr_perl, wr_perh, period_wr;
   logic               start_wr, stop_wr, start_eff, run, tc_event;
   logic               cnt_ena, cnt_sload, cnt_tc;
   logic [COUNT_W-1:0] count;

   assign wr_en     = chipselect & ~write_n;
   assign wr_status = wr_en & (address == ADDR_STATUS);
   assign wr_ctrl   = wr_en & (address == ADDR_CONTROL);
   assign wr_perl   = wr_en & (address == ADDR_PERIODL);
   assign wr_perh   = wr_en & (address == ADDR_PERIODH);
   assign period_wr = wr_perl | wr_perh;

   // STOP beats START in the same write; ALWAYS_RUN ignores STOP entirely.
   assign start_wr  = wr_ctrl & writedata[CTRL_START_BIT];
   assign stop_wr   = wr_ctrl & writedata[CTRL_STOP_BIT] & ~ALWAYS_RUN;
   assign start_eff = start_wr & ~stop_wr;

   assign run       = (state_q == RUN);
   // A period write or a restart pre-empts the terminal count.
   assign tc_event  = run & cnt_tc & ~period_wr & ~start_eff;

   assign cnt_ena   = run & ~stop_wr;
   assign cnt_sload = period_wr | start_eff | tc_event;

   // Merged period value; equals period_q when no half is being written.
   always_comb begin
      period_d = period_q;
      if (wr_perl) period_d[DATA_W-1:0]       = writedata;
      if (wr_perh) period_d[COUNT_W-1:DATA_W] = writedata;
   end

   enet_nios_timer_counter #(
      .COUNT_W   (COUNT_W),
      .RESET_VAL (RESET_PERIOD)
   ) u_counter (
      .clk        (clk),
      .reset      (reset),
      .ena        (cnt_ena),
      .sload      (cnt_sload),
      .load_value (period_d),
      .count      (count),
      .tc         (cnt_tc)
   );

   // Control FSM: next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_eff) state_d = RUN;
         RUN:     if (stop_wr || (tc_event && !cont_q)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (period_wr)  state_d = IDLE;
      if (ALWAYS_RUN) state_d = RUN;
   end

   // Status/control register next values; a TC set outranks a STATUS clear.
   always_comb begin
      to_d    = to_q;
      ito_d   = ito_q;
      cont_d  = cont_q;
      pulse_d = tc_event;
      if (wr_status) to_d = 1'b0;
      if (tc_event)  to_d = 1'b1;
      if (wr_ctrl) begin
         ito_d  = writedata[CTRL_ITO_BIT];
         cont_d = writedata[CTRL_CONT_BIT] | ALWAYS_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ALWAYS_RUN ? RUN : IDLE;
         to_q     <= 1'b0;
         ito_q    <= 1'b0;
         cont_q   <= ALWAYS_RUN;
         pulse_q  <= 1'b0;
         period_q <= RESET_PERIOD;
      end else begin
         state_q  <= state_d;
         to_q     <= to_d;
         ito_q    <= ito_d;
         cont_q   <= cont_d;
         pulse_q  <= pulse_d;
         period_q <= period_d;
      end
   end

`ifdef ENET_NIOS_TIMER_SNAPSHOT_EN
   logic               wr_snap;
   logic [COUNT_W-1:0] snap_q, snap_d;

   assign wr_snap = wr_en & ((address == ADDR_SNAPL) | (address == ADDR_SNAPH));

   always_comb begin
      snap_d = snap_q;
      if (wr_snap) snap_d = count;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         snap_q <= '0;
      end else begin
         snap_q <= snap_d;
      end
   end
`else
   logic unused_count;
   assign unused_count = ^count;
`endif

   // Zero-wait-state read mux.
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_STATUS: begin
            readdata[STATUS_TO_BIT]  = to_q;
            readdata[STATUS_RUN_BIT] = run;
         end
         ADDR_CONTROL: begin
            readdata[CTRL_ITO_BIT]  = ito_q;
            readdata[CTRL_CONT_BIT] = cont_q;
         end
         ADDR_PERIODL: readdata = period_q[DATA_W-1:0];
         ADDR_PERIODH: readdata = period_q[COUNT_W-1:DATA_W];
`ifdef ENET_NIOS_TIMER_SNAPSHOT_EN
         ADDR_SNAPL:   readdata = snap_q[DATA_W-1:0];
         ADDR_SNAPH:   readdata = snap_q[COUNT_W-1:DATA_W];
`endif
         default:      readdata = '0;
      endcase
   end

   assign irq           = to_q & ito_q;
   assign timeout_pulse = pulse_q;

endmodule

// File: tb/tb_enet_nios_period_timer.sv
// Directed self-checking bench for enet_nios_period_timer (default parameters).
module tb_enet_nios_period_timer;

   logic        clk;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;
   logic        irq;
   logic        timeout_pulse;

   int checks = 0;
   int errors = 0;

   enet_nios_period_timer dut (
      .clk           (clk),
      .reset         (reset),
      .address       (address),
      .chipselect    (chipselect),
      .write_n       (write_n),
      .writedata     (writedata),
      .readdata      (readdata),
      .irq           (irq),
      .timeout_pulse (timeout_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write committed on the first rising edge after the call; returns 1 unit after it.
   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [15:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   task automatic test_reset;
      logic [15:0] d;
      logic [15:0] exp_rd [0:7];
      int bad;
      exp_rd = '{16'h0000, 16'h0000, 16'hC34F, 16'h0000,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (timeout_pulse !== 1'b0) begin
         errors++; $display("FAIL reset_pulse: got %b expected 0", timeout_pulse);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rd(3'(i), d);
         checks++;
         if (d !== exp_rd[i]) begin
            errors++; $display("FAIL reset_read addr %0d: got %h expected %h", i, d, exp_rd[i]);
         end
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++; $display("FAIL reset_irq: got %b expected 0", irq);
      end
      bad = 0;
      repeat (60000) begin
         @(posedge clk);
         #1;
         if (timeout_pulse !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL reset_idle_pulses: got %0d pulses expected 0", bad);
      end
   endtask

   task automatic test_periodic;
      logic [15:0] d;
      logic exp_p;
      wr(3'd2, 16'd4);
      wr(3'd3, 16'd0);
      wr(3'd1, 16'h0007);
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         exp_p = (k == 5 || k == 10);
         checks++;
         if (timeout_pulse !== exp_p) begin
            errors++; $display("FAIL periodic_pulse cycle %0d: got %b expected %b", k, timeout_pulse, exp_p);
         end
         if (k == 5 || k == 10) begin
            checks++;
            if (irq !== 1'b1) begin
               errors++; $display("FAIL periodic_irq cycle %0d: got %b expected 1", k, irq);
            end
         end
      end
      wr(3'd0, 16'h0000);
      checks++;
      if (irq !== 1'b0) begin
         errors++; $display("FAIL periodic_irq_clear: got %b expected 0", irq);
      end
      wr(3'd1, 16'h0008);
      rd(3'd0, d);
      checks++;
      if (d !== 16'h0000) begin
         errors++; $display("FAIL periodic_stop_status: got %h expected 0000", d);
      end
   endtask

   task automatic test_oneshot;
      logic [15:0] d;
      logic exp_p;
      int bad;
      wr(3'd2, 16'd3);
      wr(3'd3, 16'd0);
      wr(3'd1, 16'h0005);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         exp_p = (k == 4);
         checks++;
         if (timeout_pulse !== exp_p) begin
            errors++; $display("FAIL oneshot_pulse cycle %0d: got %b expected %b", k, timeout_pulse, exp_p);
         end
      end
      checks++;
      if (irq !== 1'b1) begin
         errors++; $display("FAIL oneshot_irq: got %b expected 1", irq);
      end
      rd(3'd0, d);
      checks++;
      if (d !== 16'h0001) begin
         errors++; $display("FAIL oneshot_status: got %h expected 0001", d);
      end
      bad = 0;
      repeat (100) begin
         @(posedge clk);
         #1;
         if (timeout_pulse !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL oneshot_extra_pulses: got %0d expected 0", bad);
      end
      wr(3'd0, 16'h0000);
      rd(3'd0, d);
      checks++;
      if (d !== 16'h0000) begin
         errors++; $display("FAIL oneshot_status_clear: got %h expected 0000", d);
      end
   endtask

   task automatic test_status_collision;
      logic [15:0] d;
      wr(3'd2, 16'd2);
      wr(3'd3, 16'd0);
      wr(3'd1, 16'h0006);
      repeat (2) @(posedge clk);
      wr(3'd0, 16'h0000);
      checks++;
      if (timeout_pulse !== 1'b1) begin
         errors++; $display("FAIL collision_pulse: got %b expected 1", timeout_pulse);
      end
      rd(3'd0, d);
      checks++;
      if (d !== 16'h0003) begin
         errors++; $display("FAIL collision_to_kept: got %h expected 0003", d);
      end
      wr(3'd0, 16'h0000);
      rd(3'd0, d);
      checks++;
      if (d !== 16'h0002) begin
         errors++; $display("FAIL collision_to_cleared: got %h expected 0002", d);
      end
      wr(3'd1, 16'h0008);
      rd(3'd0, d);
      checks++;
      if (d !== 16'h0000) begin
         errors++; $display("FAIL collision_stop: got %h expected 0000", d);
      end
   endtask

   task automatic test_start_stop;
      logic [15:0] d;
      int bad;
      wr(3'd2, 16'd7);
      wr(3'd1, 16'h000E);
      rd(3'd0, d);
      checks++;
      if (d !== 16'h0000) begin
         errors++; $display("FAIL startstop_status: got %h expected 0000", d);
      end
      bad = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (timeout_pulse !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL startstop_pulses: got %0d expected 0", bad);
      end
`ifdef ENET_NIOS_TIMER_SNAPSHOT_EN
      wr(3'd4, 16'h0000);
      rd(3'd4, d);
      checks++;
      if (d !== 16'h0007) begin
         errors++; $display("FAIL startstop_count: got %h expected 0007", d);
      end
`endif
   endtask

   task automatic test_snapshot;
      logic [15:0] d;
      wr(3'd2, 16'h0000);
      wr(3'd3, 16'h0001);
      wr(3'd1, 16'h0004);
      repeat (10) @(posedge clk);
      wr(3'd4, 16'h0000);
`ifdef ENET_NIOS_TIMER_SNAPSHOT_EN
      rd(3'd4, d);
      checks++;
      if (d !== 16'hFFF6) begin
         errors++; $display("FAIL snap_low: got %h expected fff6", d);
      end
      rd(3'd5, d);
      checks++;
      if (d !== 16'h0000) begin
         errors++; $display("FAIL snap_high: got %h expected 0000", d);
      end
      repeat (5) @(posedge clk);
      wr(3'd5, 16'h0000);
      rd(3'd4, d);
      checks++;
      if (d !== 16'hFFF0) begin
         errors++; $display("FAIL snap_low_second: got %h expected fff0", d);
      end
`else
      wr(3'd5, 16'h1234);
      rd(3'd4, d);
      checks++;
      if (d !== 16'h0000) begin
         errors++; $display("FAIL snap_off_low: got %h expected 0000", d);
      end
      rd(3'd5, d);
      checks++;
      if (d !== 16'h0000) begin
         errors++; $display("FAIL snap_off_high: got %h expected 0000", d);
      end
`endif
      rd(3'd0, d);
      checks++;
      if (d !== 16'h0002) begin
         errors++; $display("FAIL snap_still_running: got %h expected 0002", d);
      end
      wr(3'd1, 16'h0008);
   endtask

   task automatic test_reset_midcount;
      logic [15:0] d;
      wr(3'd2, 16'd4);
      wr(3'd3, 16'd0);
      wr(3'd1, 16'h0007);
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (timeout_pulse !== 1'b0) begin
         errors++; $display("FAIL midreset_pulse: got %b expected 0", timeout_pulse);
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++; $display("FAIL midreset_irq: got %b expected 0", irq);
      end
      rd(3'd0, d);
      checks++;
      if (d !== 16'h0000) begin
         errors++; $display("FAIL midreset_status: got %h expected 0000", d);
      end
      rd(3'd1, d);
      checks++;
      if (d !== 16'h0000) begin
         errors++; $display("FAIL midreset_control: got %h expected 0000", d);
      end
      rd(3'd2, d);
      checks++;
      if (d !== 16'hC34F) begin
         errors++; $display("FAIL midreset_periodl: got %h expected c34f", d);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (timeout_pulse !== 1'b0) begin
         errors++; $display("FAIL midreset_pulse_after: got %b expected 0", timeout_pulse);
      end
   endtask

   initial begin
      reset      = 1'b1;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 16'h0000;
      test_reset();
      test_periodic();
      test_oneshot();
      test_status_collision();
      test_start_stop();
      test_snapshot();
      test_reset_midcount();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
